// File: rtl/rr_mux_arbiter4_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package rr_mux_arbiter4_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    // First requester at or after start, wrapping mod NREQ. Walks the
    // offsets from farthest to nearest so the nearest hit is written last
    // and wins. Returns start when nothing is requesting.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                                 input logic [SEL_W-1:0] start);
        logic [SEL_W-1:0] idx;
        rr_pick = start;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter4_pick.sv
// Rotating-priority picker: first set bit of req starting at start.
// Latency: combinational. Backpressure: none.
// Ports: req/start in, idx (winner) and any (some request present) out.
module rr_priority_pick
    import rr_mux_arbiter4_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = rr_pick(req, start);
        any = |req;
    end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter owning a shared W-bit 4:1 mux, bounded hold of MAX_HOLD.
// Latency: req->grant 1 edge; owner release -> re-grant on the same edge.
// Backpressure: losers wait while req held; owner keeps grant until drop or hold limit.
// Ports: clk, rst (sync, active-high), req[3:0], din[4*W-1:0] in;
//        grant[3:0], sel[1:0], busy (registered) and dout (mux of din) out.
module rr_mux_arbiter4
    import rr_mux_arbiter4_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] din,
    output logic [NREQ-1:0]   grant,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [W-1:0]      dout
);

    localparam int               HC_W      = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);

    state_e             state_q,    state_d;
    logic [NREQ-1:0]    grant_q,    grant_d;
    logic [SEL_W-1:0]   sel_q,      sel_d;
    logic [SEL_W-1:0]   ptr_q,      ptr_d;
    logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;

    logic [SEL_W-1:0]   pick_start;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;

    // When idle, rotation resumes from ptr; when owned, the only pick that
    // matters is the re-grant on release, which starts just past the owner.
    assign pick_start = (state_q == OWNED) ? sel_q + 2'd1 : ptr_q;

    rr_priority_pick u_pick (
        .req   (req),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;

        if (state_q == IDLE) begin
            if (pick_any) begin
                state_d    = OWNED;
                grant_d    = idx_to_onehot(pick_idx);
                sel_d      = pick_idx;
                hold_cnt_d = '0;
            end
        end else begin
            if (req[sel_q] && (hold_cnt_q < HOLD_LAST)) begin
                hold_cnt_d = hold_cnt_q + HC_W'(1);
            end else begin
                ptr_d = sel_q + 2'd1;
                if (pick_any) begin
                    // Back-to-back handover (possibly to the same owner on a
                    // timeout with no other requester) keeps grant gap-free.
                    grant_d    = idx_to_onehot(pick_idx);
                    sel_d      = pick_idx;
                    hold_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        dout = '0;
        if (state_q == OWNED) begin
            dout = din[sel_q*W +: W];
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = (state_q == OWNED);

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
module tb_rr_mux_arbiter4;

    localparam int W        = 8;
    localparam int MAX_HOLD = 8;

    logic           clk;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] din;
    logic [3:0]     grant;
    logic [1:0]     sel;
    logic           busy;
    logic [W-1:0]   dout;

    rr_mux_arbiter4 #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .grant (grant),
        .sel   (sel),
        .busy  (busy),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   grant;
        logic [1:0]   sel;
        logic         busy;
        logic [W-1:0] dout;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic       m_busy;
    logic [1:0] m_sel;
    logic [1:0] m_ptr;
    int         m_hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_pick(input logic [3:0] r, input logic [1:0] start);
        for (int k = 0; k < 4; k++) begin
            if (r[(int'(start) + k) % 4]) return 2'((int'(start) + k) % 4);
        end
        return start;
    endfunction

    task automatic model_edge(input logic [3:0] r, input logic rs);
        if (rs) begin
            m_busy = 1'b0; m_sel = 2'd0; m_ptr = 2'd0; m_hold = 0;
        end else if (!m_busy) begin
            if (r != 4'b0000) begin
                m_busy = 1'b1; m_sel = m_pick(r, m_ptr); m_hold = 0;
            end
        end else if (r[m_sel] && m_hold < MAX_HOLD - 1) begin
            m_hold++;
        end else begin
            m_ptr = m_sel + 2'd1;
            if (r != 4'b0000) begin
                m_sel = m_pick(r, m_ptr); m_hold = 0;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    // Drive one cycle, predict the post-edge outputs, then compare them.
    task automatic step(input logic [3:0] r, input logic rs);
        exp_t e;
        exp_t got_e;
        req = r;
        rst = rs;
        model_edge(r, rs);
        e.grant = m_busy ? (4'b0001 << m_sel) : 4'b0000;
        e.sel   = m_sel;
        e.busy  = m_busy;
        e.dout  = m_busy ? din[m_sel*W +: W] : '0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            got_e = sb_q.pop_front();
            chk("sb_grant", 32'(grant), 32'(got_e.grant));
            chk("sb_sel",   32'(sel),   32'(got_e.sel));
            chk("sb_busy",  32'(busy),  32'(got_e.busy));
            chk("sb_dout",  32'(dout),  32'(got_e.dout));
            chk("onehot",   32'($countones(grant) <= 1), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req = 4'b0000;
        rst = 1'b1;
        din = {8'hA5, 8'h3C, 8'h0F, 8'hF0};
        m_busy = 1'b0; m_sel = 2'd0; m_ptr = 2'd0; m_hold = 0;

        // 1: reset with req held high, then first grant
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_dout",  32'(dout),  32'h0);
        step(4'b1111, 1'b0);
        chk("first_grant", 32'(grant), 32'b0001);
        chk("first_sel",   32'(sel),   32'd0);

        // 2: single requester, drop, then ptr=3 decides next winner
        step(4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 1'b0);
            chk("single_grant", 32'(grant), 32'b0100);
        end
        step(4'b0000, 1'b0);
        chk("drop_grant", 32'(grant), 32'b0000);
        chk("drop_busy",  32'(busy),  32'd0);
        step(4'b1111, 1'b0);
        chk("ptr_grant", 32'(grant), 32'b1000);

        // 3: saturation, each owner exactly MAX_HOLD cycles in order
        step(4'b0000, 1'b1);
        for (int n = 0; n < 40; n++) begin
            step(4'b1111, 1'b0);
            chk("sat_grant", 32'(grant), 32'(4'b0001 << ((n / MAX_HOLD) % 4)));
        end

        // 4: early release skips non-requesting 1 and 2
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b1001, 1'b0);
        chk("early_hold", 32'(grant), 32'b0001);
        step(4'b1000, 1'b0);
        chk("early_grant", 32'(grant), 32'b1000);
        chk("early_sel",   32'(sel),   32'd3);
        for (int i = 0; i < MAX_HOLD - 1; i++) step(4'b1001, 1'b0);
        chk("early_cnt0", 32'(grant), 32'b1000);
        step(4'b1001, 1'b0);
        chk("early_next", 32'(grant), 32'b0001);

        // 5: sole owner timeout, no gap
        step(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(4'b0010, 1'b0);
            chk("sole_grant", 32'(grant), 32'b0010);
            chk("sole_busy",  32'(busy),  32'd1);
        end

        // 6: datapath
        step(4'b0000, 1'b1);
        step(4'b1000, 1'b0);
        chk("dp_d3", 32'(dout), 32'hA5);
        step(4'b1000, 1'b1);
        chk("dp_rst", 32'(dout), 32'h00);
        step(4'b0010, 1'b0);
        chk("dp_d1", 32'(dout), 32'h0F);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            if ((i % 37) == 0) din = {$urandom, $urandom} & {4*W{1'b1}};
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 40) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter4.md
Name: rr_mux_arbiter4

Overview:
Round-robin arbiter that shares one W-bit 4:1 multiplexed datapath among four requesters. It registers a one-hot grant and a 2-bit select, and drives the shared output from the granted requester's data. An owner may hold the resource while its request stays high, up to MAX_HOLD consecutive cycles. It sits in front of any single-consumer resource, such as a shared bus or an output register, fed by four sources.

Parameters:
W, 8, width of each requester data word and of dout
MAX_HOLD, 8, maximum consecutive cycles one grant may last (legal range >= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  request per requester, bit i = requester i
din  input  4*W  packed data, din[i*W +: W] = requester i
grant  output  4  registered one-hot grant, 0000 when idle
sel  output  2  registered index of current/last owner (drives mux select)
busy  output  1  registered, 1 while any grant is active
dout  output  W  busy ? din[sel] : 0 (combinational from registered sel/busy)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: grant=0000, sel=00, busy=0, ptr=00, hold_cnt=0, dout=0. req is ignored during the reset cycle.
- Internal state:
  - ptr[1:0]: round-robin start index.
  - hold_cnt: width $clog2(MAX_HOLD+1), counts cycles of the current grant.
- pick(req, ptr): the first index i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1. Purely combinational.
- States: IDLE (busy=0) and OWNED (busy=1). Each rising edge, with rst=0:
  - IDLE, req=0000: stay in IDLE, outputs unchanged (sel keeps its last value).
  - IDLE, req!=0: go to OWNED. grant<=onehot(pick(req,ptr)), sel<=pick, hold_cnt<=0.
  - OWNED, req[sel]=1 and hold_cnt<MAX_HOLD-1: stay, hold_cnt<=hold_cnt+1.
  - OWNED, release condition, i.e. req[sel]=0 OR hold_cnt==MAX_HOLD-1:
    - ptr<=sel+1 (wraps 3->0).
    - If req!=0: re-grant in the same edge to pick(req, sel+1), hold_cnt<=0. There is no idle bubble.
    - Else: go to IDLE, grant<=0000, busy<=0.
- Timeout with a sole requester: the same owner is re-granted and hold_cnt restarts at 0. grant shows no gap.
- Latency: req to grant is 1 edge. An owner's req drop releases grant 1 edge later.
- A requester dropping req while it is not owner has no effect. A new req that arrives while OWNED waits for the release condition.
- Fairness: with all four requesting continuously, each owner holds exactly MAX_HOLD cycles in order 0,1,2,3,0...
- Reset mid-grant: the next edge forces the reset values regardless of req or hold_cnt.
- grant is always one-hot or zero. busy == |grant. sel == index of grant whenever busy=1.

Decomposition:
- Shared package:
  - NREQ=4 and SEL_W=2.
  - State enum {IDLE, OWNED}.
  - A function for the rotating-priority pick and one for index-to-onehot.
- One natural sub-module: rr_priority_pick (combinational; inputs req[3:0] and start[1:0], outputs idx[1:0] and any). The top holds the FSM, hold counter, ptr and the output mux.

Test Plan:
1. Reset: rst=1 for 2 edges with req=1111 -> grant=0000, busy=0, dout=0. At the first edge after rst=0: grant=0001, sel=0.
2. Single requester: req=0100 for 3 cycles, then 0000 -> grant=0100 for 3 cycles. The edge after the drop gives grant=0000 and busy=0; ptr is then 3, so a following req=1111 grants 1000.
3. Saturation, MAX_HOLD=8, req=1111 steady -> grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 8 cycles, with no 0000 cycle between owners.
4. Early release: owner 0 drops req while req[3]=1 and req[1]=0 -> at the next edge grant=1000, sel=3, hold_cnt=0.
5. Sole-owner timeout: req=0010 steady for 20 cycles -> grant=0010 and busy=1 every cycle, hold_cnt wraps 7->0 twice.
6. Datapath: W=8, din words D0..D3 = F0, 0F, 3C, A5 -> dout=A5 while grant=1000 and dout=0F while grant=0010. Asserting rst during a grant gives dout=00 after that edge.
